// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator and the input-side
// measurement logic: run-state enum, per-axis timing record, and helpers.
// The optional colour-bar output is built only when
// VIDEO_TIMING_GENERATOR_PATTERN_EN is defined.
package video_timing_pkg;

   // Run-control states of the generator
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } run_state_e;

   // One raster axis: active region, then front porch, sync, back porch
   typedef struct packed {
      logic [31:0] active;
      logic [31:0] fp;
      logic [31:0] sync;
      logic [31:0] bp;
   } axis_timing_t;

   localparam int unsigned N_BARS = 8;

   // Total length of one axis (clocks per line or lines per frame)
   function automatic int unsigned total(input axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   // Bits needed to index 0..n-1, never less than one
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // 24-bit RGB of the eight standard bars, left to right
   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;   // white
         3'd1:    c = 24'hFFFF00;   // yellow
         3'd2:    c = 24'h00FFFF;   // cyan
         3'd3:    c = 24'h00FF00;   // green
         3'd4:    c = 24'hFF00FF;   // magenta
         3'd5:    c = 24'hFF0000;   // red
         3'd6:    c = 24'h0000FF;   // blue
         default: c = 24'h000000;   // black
      endcase
      return c;
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Generic raster-axis counter: counts 0..TOTAL-1 and wraps, and decodes the
// active and sync regions of the current count. Used once for the horizontal
// axis (advancing every clock) and once for the vertical axis (advancing on
// the last clock of each line).
module timing_axis_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 8,
   parameter int unsigned FP     = 2,
   parameter int unsigned SYNC   = 3,
   parameter int unsigned BP     = 3,
   parameter int unsigned W      = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o,
   output logic         active_o,
   output logic         sync_o
);

   localparam axis_timing_t TIMING = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
   localparam int unsigned  TOTAL  = total(TIMING);

   // FP and BP are at least one, so every boundary below fits in W bits
   localparam logic [W-1:0] LAST_C      = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END_C   = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG_C  = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END_C  = W'(ACTIVE + FP + SYNC);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt_o    = cnt_q;
   assign last_o   = (cnt_q == LAST_C);
   assign active_o = (cnt_q < ACT_END_C);
   assign sync_o   = (cnt_q >= SYNC_BEG_C) && (cnt_q < SYNC_END_C);

   // Next count: clear wins, otherwise advance and wrap at the last position
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: DE/HS/VS, pixel coordinates and row/frame strobes
// from compile-time timing. A small run-control FSM starts on request and
// always finishes the frame in progress before going idle.
// Define VIDEO_TIMING_GENERATOR_PATTERN_EN to add the O_rgb_data colour bars.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE         = 1920,
   parameter int unsigned H_FP             = 88,
   parameter int unsigned H_SYNC           = 44,
   parameter int unsigned H_BP             = 148,
   parameter int unsigned V_ACTIVE         = 1080,
   parameter int unsigned V_FP             = 4,
   parameter int unsigned V_SYNC           = 5,
   parameter int unsigned V_BP             = 36,
   parameter int unsigned SYNC_ACTIVE_HIGH = 1
) (
   input  logic                             I_rgb_clk,
   input  logic                             I_rst_n,
   input  logic                             I_enable,
   output logic                             O_rgb_de,
   output logic                             O_rgb_hs,
   output logic                             O_rgb_vs,
   output logic [cnt_width(H_ACTIVE)-1:0]   O_x,
   output logic [cnt_width(V_ACTIVE)-1:0]   O_y,
   output logic                             O_new_row,
   output logic                             O_new_frame,
   output logic                             O_running
`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
   ,
   output logic [23:0]                      O_rgb_data
`endif
);

   localparam axis_timing_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam axis_timing_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int unsigned  H_TOTAL  = total(H_TIMING);
   localparam int unsigned  V_TOTAL  = total(V_TIMING);
   localparam int unsigned  HW       = cnt_width(H_TOTAL);
   localparam int unsigned  VW       = cnt_width(V_TOTAL);
   localparam int unsigned  XW       = cnt_width(H_ACTIVE);
   localparam int unsigned  YW       = cnt_width(V_ACTIVE);
   localparam logic         SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

   run_state_e    state_q, state_d;
   logic          counting;
   logic          frame_last;

   logic [HW-1:0] h_cnt;
   logic          h_last, h_active, h_sync;
   logic [VW-1:0] v_cnt;
   logic          v_last, v_active, v_sync;

   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          row_q, row_d;
   logic          frame_q, frame_d;
   logic          running_q, running_d;

   assign counting   = (state_q != IDLE);
   assign frame_last = h_last && v_last;

   timing_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .W      (HW)
   ) u_h_axis (
      .clk_i    (I_rgb_clk),
      .rst_ni   (I_rst_n),
      .clr_i    (!counting),
      .inc_i    (counting),
      .cnt_o    (h_cnt),
      .last_o   (h_last),
      .active_o (h_active),
      .sync_o   (h_sync)
   );

   timing_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .W      (VW)
   ) u_v_axis (
      .clk_i    (I_rgb_clk),
      .rst_ni   (I_rst_n),
      .clr_i    (!counting),
      .inc_i    (counting && h_last),
      .cnt_o    (v_cnt),
      .last_o   (v_last),
      .active_o (v_active),
      .sync_o   (v_sync)
   );

   // Run-control: stop requests only take effect on the last clock of a frame
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (I_enable) state_d = RUN;
         RUN:      if (!I_enable) state_d = frame_last ? IDLE : STOPPING;
         STOPPING: begin
            if (I_enable) begin
               state_d = RUN;
            end else if (frame_last) begin
               state_d = IDLE;
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   // Run-state register
   always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Decode this clock's counter position into next output values
   always_comb begin
      de_d      = 1'b0;
      hs_d      = !SYNC_ON;
      vs_d      = !SYNC_ON;
      x_d       = '0;
      y_d       = '0;
      row_d     = 1'b0;
      frame_d   = 1'b0;
      running_d = 1'b0;
      if (counting) begin
         running_d = 1'b1;
         de_d      = h_active && v_active;
         hs_d      = (h_sync == SYNC_ON);
         vs_d      = (v_sync == SYNC_ON);
         x_d       = de_d ? XW'(h_cnt) : '0;
         // O_y keeps the last active line through vertical blanking
         y_d       = v_active ? YW'(v_cnt) : y_q;
         row_d     = (h_cnt == '0);
         frame_d   = (h_cnt == '0) && (v_cnt == '0);
      end
   end

   // Output registers, all one clock behind the counters
   always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         de_q      <= 1'b0;
         hs_q      <= !SYNC_ON;
         vs_q      <= !SYNC_ON;
         x_q       <= '0;
         y_q       <= '0;
         row_q     <= 1'b0;
         frame_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         de_q      <= de_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         x_q       <= x_d;
         y_q       <= y_d;
         row_q     <= row_d;
         frame_q   <= frame_d;
         running_q <= running_d;
      end
   end

   assign O_rgb_de    = de_q;
   assign O_rgb_hs    = hs_q;
   assign O_rgb_vs    = vs_q;
   assign O_x         = x_q;
   assign O_y         = y_q;
   assign O_new_row   = row_q;
   assign O_new_frame = frame_q;
   assign O_running   = running_q;

`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
   // Bar width rounds down; the clamp lets the last bar absorb the remainder
   localparam int unsigned BAR_W = (H_ACTIVE >= N_BARS) ? H_ACTIVE / N_BARS : 1;

   logic [23:0]   data_q, data_d;
   logic [HW-1:0] bar_idx;

   // Colour of the pixel being emitted, black outside the active area
   always_comb begin
      bar_idx = h_cnt / HW'(BAR_W);
      if (bar_idx > HW'(N_BARS - 1)) begin
         bar_idx = HW'(N_BARS - 1);
      end
      data_d = '0;
      if (de_d) begin
         data_d = bar_colour(3'(bar_idx));
      end
   end

   // Pixel data register, aligned with O_rgb_de
   always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign O_rgb_data = data_q;
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Self-checking bench for video_timing_generator using a small raster
// (H 8/2/3/3, V 4/1/2/1: 16 clocks per line, 128 clocks per frame).
// A second instance with inverted sync polarity runs in lock-step.
module tb_video_timing_generator;

   localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
   localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
   localparam int HT = HA + HF + HSY + HB;   // 16
   localparam int VT = VA + VF + VSY + VB;   // 8
   localparam int FT = HT * VT;              // 128

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;

   logic       de, hs, vs, nrow, nframe, run;
   logic [2:0] x;
   logic [1:0] y;
   logic       de2, hs2, vs2, nrow2, nframe2, run2;
   logic [2:0] x2;
   logic [1:0] y2;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
   logic [23:0] data1, data2, data_p;
   logic        de_p, hs_p, vs_p, nrow_p, nframe_p, run_p;
   logic [3:0]  x_p;
   logic [1:0]  y_p;

   video_timing_generator #(
      .H_ACTIVE(16), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_ACTIVE_HIGH(1)
   ) dut_p (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
      .O_rgb_de(de_p), .O_rgb_hs(hs_p), .O_rgb_vs(vs_p), .O_x(x_p), .O_y(y_p),
      .O_new_row(nrow_p), .O_new_frame(nframe_p), .O_running(run_p),
      .O_rgb_data(data_p)
   );
`endif

   video_timing_generator #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_ACTIVE_HIGH(1)
   ) dut (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
      .O_rgb_de(de), .O_rgb_hs(hs), .O_rgb_vs(vs), .O_x(x), .O_y(y),
      .O_new_row(nrow), .O_new_frame(nframe), .O_running(run)
`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
      , .O_rgb_data(data1)
`endif
   );

   video_timing_generator #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_ACTIVE_HIGH(0)
   ) dut_n (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
      .O_rgb_de(de2), .O_rgb_hs(hs2), .O_rgb_vs(vs2), .O_x(x2), .O_y(y2),
      .O_new_row(nrow2), .O_new_frame(nframe2), .O_running(run2)
`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
      , .O_rgb_data(data2)
`endif
   );

   typedef struct {
      int   n;       // clock index within the frame (0 = first output clock)
      logic de;
      logic hs;
      logic vs;
      int   x;
      int   y;
      logic row;
      logic frame;
   } vec_t;

   vec_t vtab[17];

   task automatic check(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // All outputs of both instances at their reset / idle values
   task automatic check_idle(input string tag);
      check({tag, ".de"}, int'(de), 0);
      check({tag, ".hs"}, int'(hs), 0);
      check({tag, ".vs"}, int'(vs), 0);
      check({tag, ".x"}, int'(x), 0);
      check({tag, ".y"}, int'(y), 0);
      check({tag, ".new_row"}, int'(nrow), 0);
      check({tag, ".new_frame"}, int'(nframe), 0);
      check({tag, ".running"}, int'(run), 0);
      check({tag, ".hs_low_pol"}, int'(hs2), 1);
      check({tag, ".vs_low_pol"}, int'(vs2), 1);
      check({tag, ".de_low_pol"}, int'(de2), 0);
   endtask

   // Walk one frame from its first output clock against an independent
   // raster model; optionally pulse I_enable low for five clocks mid-frame.
   task automatic scan_frame(input bit toggle, input string tag);
      int errs;
      int de_cnt;
      errs   = 0;
      de_cnt = 0;
      for (int k = 0; k < FT; k++) begin
         int   h, v, ex, ey;
         logic e_de, e_hs, e_vs;
         h    = k % HT;
         v    = k / HT;
         e_de = (h < HA) && (v < VA);
         e_hs = (h >= HA + HF) && (h < HA + HF + HSY);
         e_vs = (v >= VA + VF) && (v < VA + VF + VSY);
         ex   = e_de ? h : 0;
         ey   = (v < VA) ? v : VA - 1;
         if (de !== e_de || hs !== e_hs || vs !== e_vs || int'(x) != ex ||
             int'(y) != ey || run !== 1'b1 || nrow !== (h == 0) ||
             nframe !== (k == 0)) begin
            errs++;
         end
         if (hs2 !== ~hs || vs2 !== ~vs || de2 !== de || nframe2 !== nframe) begin
            errs++;
         end
         if (de === 1'b1) de_cnt++;
         if (toggle && k == 30) en = 1'b0;
         if (toggle && k == 35) en = 1'b1;
         @(negedge clk);
      end
      check({tag, ".model_errs"}, errs, 0);
      check({tag, ".de_count"}, de_cnt, HA * VA);
      check({tag, ".period_128"}, int'(nframe), 1);
   endtask

   initial begin
      int cur;
      int pulses;

      // n:  de hs vs  x  y row frame
      vtab[0]  = '{0,   1, 0, 0, 0, 0, 1, 1};
      vtab[1]  = '{1,   1, 0, 0, 1, 0, 0, 0};
      vtab[2]  = '{7,   1, 0, 0, 7, 0, 0, 0};
      vtab[3]  = '{8,   0, 0, 0, 0, 0, 0, 0};
      vtab[4]  = '{9,   0, 0, 0, 0, 0, 0, 0};
      vtab[5]  = '{10,  0, 1, 0, 0, 0, 0, 0};
      vtab[6]  = '{12,  0, 1, 0, 0, 0, 0, 0};
      vtab[7]  = '{13,  0, 0, 0, 0, 0, 0, 0};
      vtab[8]  = '{16,  1, 0, 0, 0, 1, 1, 0};
      vtab[9]  = '{55,  1, 0, 0, 7, 3, 0, 0};
      vtab[10] = '{64,  0, 0, 0, 0, 3, 1, 0};
      vtab[11] = '{79,  0, 0, 0, 0, 3, 0, 0};
      vtab[12] = '{80,  0, 0, 1, 0, 3, 1, 0};
      vtab[13] = '{90,  0, 1, 1, 0, 3, 0, 0};
      vtab[14] = '{111, 0, 0, 1, 0, 3, 0, 0};
      vtab[15] = '{112, 0, 0, 0, 0, 3, 1, 0};
      vtab[16] = '{128, 1, 0, 0, 0, 0, 1, 1};

      // Reset held with the run request already high
      rst_n = 1'b0;
      en    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_idle("reset");

      // First output frame appears two clocks after reset release
      rst_n = 1'b1;
      @(negedge clk);
      check("start+1.new_frame", int'(nframe), 0);
      check("start+1.running", int'(run), 0);
      @(negedge clk);
      check("start+2.new_frame", int'(nframe), 1);
      check("start+2.running", int'(run), 1);

      // Directed vectors across the first frame and into the second
      cur = 0;
      for (int i = 0; i < 17; i++) begin
         string t;
         while (cur < vtab[i].n) begin
            @(negedge clk);
            cur++;
         end
         t = $sformatf("vec%0d(n=%0d)", i, vtab[i].n);
         check({t, ".de"}, int'(de), int'(vtab[i].de));
         check({t, ".hs"}, int'(hs), int'(vtab[i].hs));
         check({t, ".vs"}, int'(vs), int'(vtab[i].vs));
         check({t, ".x"}, int'(x), vtab[i].x);
         check({t, ".y"}, int'(y), vtab[i].y);
         check({t, ".new_row"}, int'(nrow), int'(vtab[i].row));
         check({t, ".new_frame"}, int'(nframe), int'(vtab[i].frame));
         check({t, ".hs_low_pol"}, int'(hs2), int'(!vtab[i].hs));
         check({t, ".vs_low_pol"}, int'(vs2), int'(!vtab[i].vs));
      end

      // Full frame against the model, then a frame with an enable glitch
      scan_frame(1'b0, "frame_free");
      scan_frame(1'b1, "frame_toggle");

      // Stop request at h=3, v=1: the frame still runs to its last clock
      cur = 0;
      while (cur < 19) begin
         @(negedge clk);
         cur++;
      end
      en = 1'b0;
      while (cur < FT - 1) begin
         @(negedge clk);
         cur++;
      end
      check("stop.last_clock_running", int'(run), 1);
      check("stop.last_clock_vs", int'(vs), 0);
      @(negedge clk);
      check_idle("stopped");
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (nframe === 1'b1 || run === 1'b1 || de === 1'b1) pulses++;
      end
      check("idle.no_activity", pulses, 0);

      // Re-enable: new frame two clocks later
      en = 1'b1;
      @(negedge clk);
      check("reenable+1.new_frame", int'(nframe), 0);
      @(negedge clk);
      check("reenable+2.new_frame", int'(nframe), 1);
      check("reenable+2.new_row", int'(nrow), 1);

      // Asynchronous reset in the middle of an active line (h=5)
      for (int k = 0; k < 5; k++) @(negedge clk);
      check("pre_reset.de", int'(de), 1);
      check("pre_reset.x", int'(x), 5);
      #2 rst_n = 1'b0;
      #1 check_idle("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart+1.new_frame", int'(nframe), 0);
      @(negedge clk);
      check("restart+2.new_frame", int'(nframe), 1);
      check("restart+2.x", int'(x), 0);
      check("restart+2.y", int'(y), 0);

`ifdef VIDEO_TIMING_GENERATOR_PATTERN_EN
      // Colour bars on the 16-pixel instance, restarted in step with dut
      check("pat.new_frame", int'(nframe_p), 1);
      for (int k = 0; k <= 16; k++) begin
         if (k == 0 || k == 1) check($sformatf("pat.x%0d", k), int'(data_p), 24'hFFFFFF);
         if (k == 2) check("pat.x2", int'(data_p), 24'hFFFF00);
         if (k == 14 || k == 15) check($sformatf("pat.x%0d", k), int'(data_p), 24'h000000);
         if (k == 16) check("pat.blank", int'(data_p), 0);
         @(negedge clk);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Transmit-side counterpart of the input sync/size measurement logic.
- Generates DE/HS/VS raster timing plus pixel coordinates and row/frame strobes from compile-time timing parameters.
- Drives the matrix test/output path and loop-back benches of the HDMI input chain.
- Start/stop is frame-aligned via a small run-control FSM.

Parameters:
- H_ACTIVE, 1920, active pixels per line (≥1)
- H_FP, 88, horizontal front porch in clocks (≥1)
- H_SYNC, 44, HS pulse width in clocks (≥1)
- H_BP, 148, horizontal back porch in clocks (≥1)
- V_ACTIVE, 1080, active lines per frame (≥1)
- V_FP, 4, vertical front porch in lines (≥1)
- V_SYNC, 5, VS pulse width in lines (≥1)
- V_BP, 36, vertical back porch in lines (≥1)
- SYNC_ACTIVE_HIGH, 1, 1 = HS/VS asserted high; 0 = asserted low

Ports:
- I_rgb_clk  input  1  pixel clock
- I_rst_n  input  1  asynchronous active-low reset
- I_enable  input  1  run request
- O_rgb_de  output  1  data enable, high during active pixels
- O_rgb_hs  output  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- O_rgb_vs  output  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- O_x  output  $clog2(H_ACTIVE)  active pixel column; 0 when DE low
- O_y  output  $clog2(V_ACTIVE)  active line; holds the last active line outside active area
- O_new_row  output  1  one-cycle pulse on the first clock of each line (h==0)
- O_new_frame  output  1  one-cycle pulse on the first clock of each frame (h==0, v==0)
- O_running  output  1  high while FSM is in RUN or STOPPING

Behaviour:
- Widths:
  - H_TOTAL = sum of the four H_ parameters; V_TOTAL = sum of the four V_ parameters.
  - h_cnt is $clog2(H_TOTAL) bits; v_cnt is $clog2(V_TOTAL) bits.
- Line layout (h_cnt): active [0,H_ACTIVE), then FP, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP.
- Frame layout (v_cnt): same order, in lines.
- VS transitions occur only when h_cnt==0.
- Counters:
  - h_cnt wraps H_TOTAL-1 → 0 and increments v_cnt.
  - v_cnt wraps V_TOTAL-1 → 0.
- Latency: every output is registered and reflects the counter state of the previous clock, so all outputs are mutually aligned.
  - O_x equals h_cnt while DE is high.
  - O_y equals v_cnt while in active lines.
- Reset:
  - FSM=IDLE; counters 0.
  - O_rgb_de=0, O_new_row=0, O_new_frame=0, O_running=0, O_x=0, O_y=0.
  - O_rgb_hs and O_rgb_vs at their inactive level (0 if SYNC_ACTIVE_HIGH, else 1).
- FSM states:
  - IDLE: counters held at 0, outputs inactive. I_enable=1 → RUN; the first output cycle is h=0, v=0 with O_new_frame=1 and O_new_row=1.
  - RUN: counters free-run. I_enable=0 → STOPPING.
  - STOPPING: keeps running to the end of the current frame. At h=H_TOTAL-1 and v=V_TOTAL-1 → IDLE. If I_enable=1 returns before the frame ends → RUN with no timing glitch.
- Boundary conditions:
  - I_enable toggled within one frame never truncates a frame or line.
  - Asynchronous reset mid-frame forces reset values immediately; operation restarts from IDLE.
  - I_enable=1 held through reset release gives a first frame starting two clocks after deassertion (IDLE→RUN, then first output register).
- With the default parameters, an HS falling edge (active-high polarity) is followed by exactly H_ACTIVE DE-high clocks per line.
  - A receiver counting DE between HS falling edges measures width H_ACTIVE and height V_ACTIVE.

Optional Feature:
- Macro: VIDEO_TIMING_GENERATOR_PATTERN_EN.
- Enabled:
  - Adds output O_rgb_data (24 bits).
  - Eight vertical colour bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black, encoded 8 bits per channel as 00 or FF.
  - Registered and aligned with O_rgb_de; 0 when DE low.
  - The last bar absorbs the H_ACTIVE remainder.
- Disabled: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package video_timing_pkg holds:
  - the run-state enum (IDLE, RUN, STOPPING);
  - a timing-struct typedef (active/fp/sync/bp);
  - helper function total(), shared with the input-side measurement logic for consistency checks.
- One natural sub-module, timing_axis_counter: a generic counter with wrap and region decode (active/sync flags), instantiated once for the horizontal axis and once for the vertical axis.

Test Plan:
- Small timing H=8/2/3/3 (H_TOTAL 16), V=4/1/2/1 (V_TOTAL 8), I_enable=1 after reset:
  - O_new_frame pulses every 128 clocks.
  - 32 DE-high clocks per frame.
  - HS high on h 10..12.
  - VS high on lines 5..6.
- Same config, check coordinates: O_x steps 0..7 with DE; O_y steps 0..3; both 0 at the first DE of a frame.
- Drop I_enable at h=3, v=1:
  - Frame continues to h=15, v=7.
  - Then O_running=0 and all outputs inactive.
  - Re-enable: O_new_frame appears 2 clocks later.
- Toggle I_enable 1→0→1 within one frame: no missing or extra lines; period stays 128.
- SYNC_ACTIVE_HIGH=0: HS/VS inverted, reset level 1, DE unchanged.
- Assert reset mid-line at h=5: all outputs go to reset values in the same cycle. With VIDEO_TIMING_GENERATOR_PATTERN_EN (H_ACTIVE=16), O_rgb_data=FFFFFF for x=0..1 and 000000 for x=14..15.
